rst_sequencer: RTL and testbench

- Power-on and software reset controller for the multi-clock system.
- Synchronizes the deassertion of the asynchronous system reset. Holds all domains in reset for a fixed interval, then releases NUM_DOMAINS per-domain resets in a fixed order (index 0 first) with a programmable gap between releases.
- Each DOMAIN_RST_N output feeds that domain's local reset synchronizer.
- A software request re-runs the full sequence without toggling RST.

---
 rtl/rst_sequencer_pkg.sv | 21 ++
 rtl/rst_seq_sync.sv | 23 ++
 rtl/rst_sequencer.sv | 139 +++++++++++++
 tb/tb_rst_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/rst_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM encodings and default parameter values.
package rst_sequencer_pkg;

  localparam logic [1:0] RESET   = 2'd0;
  localparam logic [1:0] HOLD    = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  typedef enum logic [1:0] {
    StReset   = RESET,
    StHold    = HOLD,
    StRelease = RELEASE,
    StDone    = DONE
  } seq_state_e;

  localparam int unsigned DEF_NUM_STAGES  = 2;
  localparam int unsigned DEF_NUM_DOMAINS = 3;
  localparam int unsigned DEF_HOLD_CYCLES = 4;
  localparam int unsigned DEF_GAP_W       = 4;

endpackage

// File: rtl/rst_seq_sync.sv
// Deassertion synchronizer for the asynchronous system reset: asserts immediately,
// releases NUM_STAGES clock edges after RST goes high.
module rst_seq_sync #(
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RST,
  output logic SYNC_RST_N
);

  logic [NUM_STAGES-1:0] sync_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign SYNC_RST_N = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / software reset sequencer: holds all domains in reset, then releases them in
// ascending order with a programmable gap. All outputs are driven straight from flops.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = DEF_NUM_STAGES,
  parameter int unsigned NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned GAP_W       = DEF_GAP_W
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [GAP_W-1:0]       CFG_GAP,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST_N,
  output logic                   SEQ_BUSY,
  output logic                   SEQ_DONE
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_DOMAINS + 1);

  // Counters hold "edges remaining minus one", so a zero count means release on this edge.
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

  logic sync_rst_n;

  rst_seq_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_sync (
    .CLK        (CLK),
    .RST        (RST),
    .SYNC_RST_N (sync_rst_n)
  );

  seq_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [GAP_W-1:0]       gap_load;

  // A zero gap behaves as a gap of one edge.
  assign gap_load = (CFG_GAP == '0) ? '0 : CFG_GAP - GAP_W'(1);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    busy_d  = busy_q;
    done_d  = done_q;

    unique case (state_q)
      StReset: begin
        if (sync_rst_n) begin
          state_d = StHold;
          hold_d  = HOLD_LOAD;
        end
      end
      StHold: begin
        if (hold_q == '0) begin
          dom_d[0] = 1'b1;
          if (NUM_DOMAINS == 1) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StRelease;
            idx_d   = IDX_W'(1);
            gap_d   = gap_load;
          end
        end else begin
          hold_d = hold_q - HOLD_W'(1);
        end
      end
      StRelease: begin
        if (gap_q == '0) begin
          dom_d[idx_q] = 1'b1;
          gap_d        = gap_load;
          if (idx_q == IDX_LAST) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      StDone: begin
      end
      default: begin
        state_d = StReset;
      end
    endcase

    // Software request restarts the hold interval from any state except RESET.
    if (SW_RST_REQ && (state_q != StReset)) begin
      state_d = StHold;
      hold_d  = HOLD_LOAD;
      gap_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= StReset;
      hold_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DOMAIN_RST_N = dom_q;
  assign SEQ_BUSY     = busy_q;
  assign SEQ_DONE     = done_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer at default parameters; edge numbers follow the
// convention that edge 1 is the first rising edge after RST is released.
module tb_rst_sequencer;
  import rst_sequencer_pkg::*;

  localparam int unsigned ND = DEF_NUM_DOMAINS;
  localparam int unsigned GW = DEF_GAP_W;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          SW_RST_REQ = 1'b0;
  logic [GW-1:0] CFG_GAP = GW'(2);
  logic [ND-1:0] DOMAIN_RST_N;
  logic          SEQ_BUSY;
  logic          SEQ_DONE;

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;

  always #5 CLK = ~CLK;

  rst_sequencer #(
    .NUM_STAGES  (DEF_NUM_STAGES),
    .NUM_DOMAINS (ND),
    .HOLD_CYCLES (DEF_HOLD_CYCLES),
    .GAP_W       (GW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .SW_RST_REQ   (SW_RST_REQ),
    .CFG_GAP      (CFG_GAP),
    .DOMAIN_RST_N (DOMAIN_RST_N),
    .SEQ_BUSY     (SEQ_BUSY),
    .SEQ_DONE     (SEQ_DONE)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to edge 'last', checking outputs after every edge against release edges r0..r2.
  task automatic run_to(input int last, input int r0, input int r1, input int r2);
    logic [2:0] exp_dom;
    while (edge_n < last) begin
      @(posedge CLK);
      #1;
      edge_n++;
      exp_dom = {edge_n >= r2, edge_n >= r1, edge_n >= r0};
      check_eq($sformatf("dom@e%0d", edge_n), 32'(DOMAIN_RST_N), 32'(exp_dom));
      check_eq($sformatf("done@e%0d", edge_n), 32'(SEQ_DONE), 32'(edge_n >= r2));
      check_eq($sformatf("busy@e%0d", edge_n), 32'(SEQ_BUSY), 32'(edge_n < r2));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_dom"}, 32'(DOMAIN_RST_N), 32'd0);
    check_eq({tag, "_busy"}, 32'(SEQ_BUSY), 32'd1);
    check_eq({tag, "_done"}, 32'(SEQ_DONE), 32'd0);
  endtask

  // Hold RST low for two edges, then release it just after an edge so the next one is edge 1.
  task automatic restart(input int gap);
    RST        = 1'b0;
    SW_RST_REQ = 1'b0;
    CFG_GAP    = GW'(gap);
    repeat (2) @(posedge CLK);
    #1;
    RST    = 1'b1;
    edge_n = 0;
  endtask

  initial begin
    #1 RST = 1'b0;
    #2 check_reset_outputs("por");

    // Power-on order with gap 2, then software request sampled on edge 20 in DONE.
    restart(2);
    run_to(19, 7, 9, 11);
    SW_RST_REQ = 1'b1;
    run_to(20, 24, 26, 28);
    SW_RST_REQ = 1'b0;
    run_to(30, 24, 26, 28);
    // Request held high on edges 31..33 delays release to 4 edges after the last.
    SW_RST_REQ = 1'b1;
    run_to(33, 37, 39, 41);
    SW_RST_REQ = 1'b0;
    run_to(42, 37, 39, 41);

    // Gap 0 behaves as gap 1.
    restart(0);
    run_to(10, 7, 8, 9);

    // Software request mid-release, sampled on edge 8.
    restart(2);
    run_to(7, 7, 9, 11);
    SW_RST_REQ = 1'b1;
    run_to(8, 12, 14, 16);
    SW_RST_REQ = 1'b0;
    run_to(17, 12, 14, 16);

    // RST asserted between edges 9 and 10 clears outputs without a clock edge.
    restart(2);
    run_to(9, 7, 9, 11);
    #2 RST = 1'b0;
    #1 check_reset_outputs("async_rst");
    restart(2);
    run_to(12, 7, 9, 11);

    // Gap change mid-gap is ignored until the next load.
    restart(2);
    run_to(7, 7, 9, 11);
    CFG_GAP = GW'(5);
    run_to(15, 7, 9, 14);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
